flac_encoder_complete: RTL and testbench

Streaming FLAC-style lossless encoder core. Reads `numSamples` signed 16-bit PCM samples from an external sample memory through an address port. Emits the first two samples verbatim as warm-up words, then emits Rice-coded residuals of a fixed order-2 predictor. Output is packed MSB-first into 16-bit words on an address/data port that the external memory captures every clock.

---
 rtl/flac_enc_pkg.sv | 28 ++
 rtl/flac_bit_packer.sv | 56 +++++
 rtl/flac_encoder_complete.sv | 165 ++++++++++++++++
 tb/tb_flac_encoder_complete.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flac_enc_pkg.sv
// Shared state encoding, datapath widths and the residual zigzag map
// for the FLAC-style encoder.
package flac_enc_pkg;

   localparam int SAMPLE_W = 16;
   localparam int RES_W    = 19;
   localparam int WORD_W   = 16;

   typedef enum logic [3:0] {
      INIT  = 4'd0,
      FETCH = 4'd1,
      WARM  = 4'd2,
      RESID = 4'd3,
      UNARY = 4'd4,
      STOP  = 4'd5,
      BIN   = 4'd6,
      NEXT  = 4'd7,
      DONE  = 4'd8
   } encState_t;

   // Signed residual to unsigned code: e>=0 -> 2e, e<0 -> -2e-1 (== ~(2e)).
   function automatic logic [RES_W-1:0] zigzag(input logic signed [RES_W-1:0] e);
      logic [RES_W-1:0] dbl;
      dbl = {e[RES_W-2:0], 1'b0};
      return e[RES_W-1] ? ~dbl : dbl;
   endfunction

endpackage

// File: rtl/flac_bit_packer.sv
// MSB-first bit packer owning the output word and its address; the address
// advances lazily, only when new data needs a fresh word. Debug port under FLAC_DEBUG_PORTS_EN.
module flac_bit_packer
   import flac_enc_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              clear,
   input  logic [ADDR_W-1:0] startAddr,
   input  logic              bitValid,
   input  logic              bitIn,
   input  logic              wordLoad,
   input  logic [WORD_W-1:0] wordIn,
   output logic [ADDR_W-1:0] oAddress,
   output logic [WORD_W-1:0] oMemory
`ifdef FLAC_DEBUG_PORTS_EN
   ,
   output logic [3:0]        bitPtr
`endif
);

   // Bits already placed in the current word; 0 means the word is still empty.
   logic [4:0] fill;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         oAddress <= '0;
         oMemory  <= '0;
         fill     <= '0;
      end else if (clear) begin
         oAddress <= startAddr;
         oMemory  <= '0;
         fill     <= '0;
      end else if (wordLoad) begin
         if (fill != 5'd0) oAddress <= oAddress + ADDR_W'(1);
         oMemory <= wordIn;
         fill    <= 5'd16;
      end else if (bitValid) begin
         if (fill == 5'd16) begin
            oAddress <= oAddress + ADDR_W'(1);
            oMemory  <= {bitIn, {(WORD_W-1){1'b0}}};
            fill     <= 5'd1;
         end else begin
            oMemory[4'd15 - fill[3:0]] <= bitIn;
            fill <= fill + 5'd1;
         end
      end
   end

`ifdef FLAC_DEBUG_PORTS_EN
   assign bitPtr = fill[3:0];
`endif

endmodule

// File: rtl/flac_encoder_complete.sv
// FLAC-style encoder: two verbatim warm-up words, then Rice-coded order-2
// residuals packed MSB-first. Optional debug outputs under FLAC_DEBUG_PORTS_EN.
module flac_encoder_complete #(
   parameter int RICE_K   = 4,
   parameter int SAMPLE_W = 16,
   parameter int ADDR_W   = 16
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic [ADDR_W-1:0]          numSamples,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic [ADDR_W-1:0]          iAddressStart,
   output logic [ADDR_W-1:0]          iAddress,
   input  logic [ADDR_W-1:0]          oAddressStart,
   output logic [ADDR_W-1:0]          oAddress,
   output logic [15:0]                oMemory,
   output logic                       done
`ifdef FLAC_DEBUG_PORTS_EN
   ,
   output logic [3:0]                 state,
   output logic [ADDR_W-1:0]          sampleCount,
   output logic signed [18:0]         residual,
   output logic [3:0]                 bitPtr
`endif
);
   import flac_enc_pkg::*;

   localparam logic [RES_W-1:0] REM_MASK = RES_W'((1 << RICE_K) - 1);

   logic [1:0]                 rstSync;
   logic                       run;
   encState_t                  curState, nextState;
   logic [ADDR_W-1:0]          numLat, sampleCnt, sampleCntInc;
   logic signed [SAMPLE_W-1:0] cur, prev1, prev2;
   logic                       fetchWait;
   logic signed [RES_W-1:0]    eNow;
   logic [RES_W-1:0]           uNow, quot, remBits;
   logic [3:0]                 bitIdx;
   logic                       pkClear, pkBitValid, pkBitIn, pkWordLoad;

   // Core stays in INIT until the release has passed through both flops.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) rstSync <= '0;
      else         rstSync <= {rstSync[0], 1'b1};
   end
   assign run = rstSync[1];

   assign eNow         = RES_W'(cur) - (RES_W'(prev1) <<< 1) + RES_W'(prev2);
   assign uNow         = zigzag(eNow);
   assign sampleCntInc = sampleCnt + ADDR_W'(1);
   assign done         = (curState == DONE);

   always_comb begin
      nextState  = curState;
      pkClear    = 1'b0;
      pkBitValid = 1'b0;
      pkBitIn    = 1'b0;
      pkWordLoad = 1'b0;
      case (curState)
         INIT:  if (run) begin
                   pkClear   = 1'b1;
                   nextState = (numSamples == '0) ? DONE : FETCH;
                end
         FETCH: if (fetchWait) nextState = (sampleCnt < ADDR_W'(2)) ? WARM : RESID;
         WARM:  begin
                   pkWordLoad = 1'b1;
                   nextState  = NEXT;
                end
         RESID: nextState = ((uNow >> RICE_K) != '0) ? UNARY : STOP;
         UNARY: begin
                   pkBitValid = 1'b1;
                   if (quot == RES_W'(1)) nextState = STOP;
                end
         STOP:  begin
                   pkBitValid = 1'b1;
                   pkBitIn    = 1'b1;
                   nextState  = (RICE_K == 0) ? NEXT : BIN;
                end
         BIN:   begin
                   pkBitValid = 1'b1;
                   pkBitIn    = remBits[bitIdx];
                   if (bitIdx == 4'd0) nextState = NEXT;
                end
         NEXT:  nextState = (sampleCntInc == numLat) ? DONE : FETCH;
         DONE:  nextState = DONE;
         default: nextState = INIT;
      endcase
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         curState  <= INIT;
         numLat    <= '0;
         sampleCnt <= '0;
         iAddress  <= '0;
         cur       <= '0;
         prev1     <= '0;
         prev2     <= '0;
         fetchWait <= 1'b0;
         quot      <= '0;
         remBits   <= '0;
         bitIdx    <= '0;
      end else begin
         curState <= nextState;
         case (curState)
            INIT:  if (run) begin
                      numLat   <= numSamples;
                      iAddress <= iAddressStart;
                   end
            // First FETCH cycle covers the memory's read latency.
            FETCH: if (!fetchWait) begin
                      fetchWait <= 1'b1;
                   end else begin
                      fetchWait <= 1'b0;
                      prev2     <= prev1;
                      prev1     <= cur;
                      cur       <= iSample;
                   end
            RESID: begin
                      quot    <= uNow >> RICE_K;
                      remBits <= uNow & REM_MASK;
                      bitIdx  <= 4'(RICE_K - 1);
                   end
            UNARY: quot <= quot - RES_W'(1);
            BIN:   bitIdx <= bitIdx - 4'd1;
            NEXT:  begin
                      sampleCnt <= sampleCntInc;
                      if (sampleCntInc != numLat) iAddress <= iAddress + ADDR_W'(1);
                   end
            default: ;
         endcase
      end
   end

   flac_bit_packer #(.ADDR_W(ADDR_W)) packer (
      .iClock   (iClock),
      .iReset   (iReset),
      .clear    (pkClear),
      .startAddr(oAddressStart),
      .bitValid (pkBitValid),
      .bitIn    (pkBitIn),
      .wordLoad (pkWordLoad),
      .wordIn   (WORD_W'(cur)),
      .oAddress (oAddress),
      .oMemory  (oMemory)
`ifdef FLAC_DEBUG_PORTS_EN
      ,
      .bitPtr   (bitPtr)
`endif
   );

`ifdef FLAC_DEBUG_PORTS_EN
   logic signed [RES_W-1:0] resid;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset)                resid <= '0;
      else if (curState == RESID) resid <= eNow;
   end

   assign state       = curState;
   assign sampleCount = sampleCnt;
   assign residual    = resid;
`endif

endmodule

// File: tb/tb_flac_encoder_complete.sv
// Bench for flac_encoder_complete: three instances (k=0,1,2) share one input
// memory; each output memory is compared with a bit-stream reference model.
module tb_flac_encoder_complete;

   localparam int NK     = 3;
   localparam int ADDR_W = 16;
   localparam int IMEM   = 256;
   localparam int OMEM   = 1024;
   localparam int MAXCYC = 40000;

   logic clk  = 1'b0;
   logic rstN = 1'b1;
   logic wipe = 1'b0;
   logic [ADDR_W-1:0] numSamples    = '0;
   logic [ADDR_W-1:0] iAddressStart = '0;
   logic [ADDR_W-1:0] oAddressStart = '0;

   logic signed [15:0] inMem [IMEM];
   logic signed [15:0] iSample [NK];
   logic [ADDR_W-1:0]  iAddress [NK];
   logic [ADDR_W-1:0]  oAddress [NK];
   logic [15:0]        oMemory [NK];
   logic               done [NK];
   logic [15:0]        outMem [NK][OMEM];
   int unsigned        addrViol [NK];
   logic [15:0]        expQ [$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NK; g++) begin : gDut
      flac_encoder_complete #(.RICE_K(g), .SAMPLE_W(16), .ADDR_W(ADDR_W)) dut (
         .iClock       (clk),
         .iReset       (rstN),
         .numSamples   (numSamples),
         .iSample      (iSample[g]),
         .iAddressStart(iAddressStart),
         .iAddress     (iAddress[g]),
         .oAddressStart(oAddressStart),
         .oAddress     (oAddress[g]),
         .oMemory      (oMemory[g]),
         .done         (done[g])
      );
   end

   // Synchronous-read input memory and write-every-cycle output memory.
   always @(posedge clk) begin
      for (int g = 0; g < NK; g++) begin
         iSample[g] <= inMem[iAddress[g][7:0]];
         if (wipe) begin
            for (int a = 0; a < OMEM; a++) outMem[g][a] <= 16'hDEAD;
            addrViol[g] <= 0;
         end else begin
            outMem[g][oAddress[g][9:0]] <= oMemory[g];
            if (rstN && numSamples != '0 && iAddress[g] >= iAddressStart + numSamples)
               addrViol[g] <= addrViol[g] + 1;
         end
      end
   end

   // Reference: build the whole bit stream, then cut it into 16-bit words.
   task automatic modelEncode(input int k, input int n, input int base);
      int bits [$];
      int e, u, q;
      logic [15:0] w;
      expQ.delete();
      for (int i = 0; i < n && i < 2; i++) expQ.push_back(inMem[base + i]);
      for (int i = 2; i < n; i++) begin
         e = int'(inMem[base + i]) - 2 * int'(inMem[base + i - 1]) + int'(inMem[base + i - 2]);
         u = (e >= 0) ? 2 * e : -2 * e - 1;
         q = u >> k;
         repeat (q) bits.push_back(0);
         bits.push_back(1);
         for (int b = k - 1; b >= 0; b--) bits.push_back((u >> b) & 1);
      end
      for (int i = 0; i < bits.size(); i += 16) begin
         w = '0;
         for (int j = 0; j < 16 && i + j < bits.size(); j++) w[15 - j] = (bits[i + j] != 0);
         expQ.push_back(w);
      end
   endtask

   task automatic startEncode(input int n, input int iStart, input int oStart);
      @(negedge clk);
      rstN = 1'b0;
      wipe = 1'b1;
      numSamples    = ADDR_W'(n);
      iAddressStart = ADDR_W'(iStart);
      oAddressStart = ADDR_W'(oStart);
      @(negedge clk);
      wipe = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic runEncode(input int n, input int iStart, input int oStart);
      int cycles;
      startEncode(n, iStart, oStart);
      cycles = 0;
      while (!(done[0] && done[1] && done[2]) && cycles < MAXCYC) begin
         @(negedge clk);
         cycles++;
      end
      repeat (3) @(negedge clk);
      tests++;
      if (cycles >= MAXCYC) begin
         fails++;
         $display("FAIL timeout: done=%b%b%b after %0d cycles, required 111", done[0], done[1], done[2], cycles);
      end
   endtask

   task automatic test_reset();
      #2 rstN = 1'b0;
      #1;
      for (int g = 0; g < NK; g++) begin
         tests++;
         if (iAddress[g] !== '0 || oAddress[g] !== '0 || oMemory[g] !== '0 || done[g] !== 1'b0) begin
            fails++;
            $display("FAIL reset k=%0d: iA=%h oA=%h oM=%h done=%b, required all 0",
                     g, iAddress[g], oAddress[g], oMemory[g], done[g]);
         end
      end
   endtask

   task automatic test_vectors();
      logic [15:0] vecS [3][4] = '{'{16'h0000, 16'h0000, 16'h0000, 16'h0000},
                                   '{16'h0001, 16'h0002, 16'h0003, 16'h0005},
                                   '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000}};
      int          vecN [3] = '{4, 4, 3};
      logic [15:0] vecW [3] = '{16'h9000, 16'h9000, 16'h4000};
      int          expLast;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 4; i++) inMem[i] = vecS[c][i];
         runEncode(vecN[c], 0, 0);
         tests++;
         if (outMem[2 - c][2] !== vecW[c] || oAddress[2 - c] !== 16'd2) begin
            fails++;
            $display("FAIL vector%0d k=%0d: addr2=%h oA=%h, required %h / 0002",
                     c, 2 - c, outMem[2 - c][2], oAddress[2 - c], vecW[c]);
         end
         for (int g = 0; g < NK; g++) begin
            modelEncode(g, vecN[c], 0);
            for (int w = 0; w < expQ.size(); w++) begin
               tests++;
               if (outMem[g][w] !== expQ[w]) begin
                  fails++;
                  $display("FAIL vector%0d word k=%0d addr=%0d: got %h want %h", c, g, w, outMem[g][w], expQ[w]);
               end
            end
            expLast = expQ.size() - 1;
            tests++;
            if (oAddress[g] !== ADDR_W'(expLast) || done[g] !== 1'b1) begin
               fails++;
               $display("FAIL vector%0d end k=%0d: oA=%h done=%b, want %h / 1", c, g, oAddress[g], done[g], ADDR_W'(expLast));
            end
         end
      end
   endtask

   task automatic test_boundary();
      logic [15:0] fillWords [3][3] = '{'{16'hFFFF, 16'hDEAD, 16'hDEAD},
                                        '{16'hAAAA, 16'hAAAA, 16'hDEAD},
                                        '{16'h9249, 16'h2492, 16'h4924}};
      // numSamples = 0
      runEncode(0, 5, 7);
      for (int g = 0; g < NK; g++) begin
         tests++;
         if (done[g] !== 1'b1 || oAddress[g] !== 16'd7 || iAddress[g] !== 16'd5 || oMemory[g] !== '0) begin
            fails++;
            $display("FAIL empty k=%0d: done=%b oA=%h iA=%h oM=%h, want 1/0007/0005/0000",
                     g, done[g], oAddress[g], iAddress[g], oMemory[g]);
         end
      end
      // numSamples = 1 and 2: verbatim words only
      inMem[10] = 16'sh1234;
      runEncode(1, 10, 9);
      for (int g = 0; g < NK; g++) begin
         tests++;
         if (outMem[g][9] !== 16'h1234 || oAddress[g] !== 16'd9 || done[g] !== 1'b1 || addrViol[g] != 0) begin
            fails++;
            $display("FAIL one k=%0d: word=%h oA=%h done=%b viol=%0d, want 1234/0009/1/0",
                     g, outMem[g][9], oAddress[g], done[g], addrViol[g]);
         end
      end
      inMem[20] = 16'sh8000;
      inMem[21] = 16'sh7FFF;
      runEncode(2, 20, 20);
      for (int g = 0; g < NK; g++) begin
         tests++;
         if (outMem[g][20] !== 16'h8000 || outMem[g][21] !== 16'h7FFF || oAddress[g] !== 16'd21 || done[g] !== 1'b1) begin
            fails++;
            $display("FAIL two k=%0d: words=%h %h oA=%h done=%b, want 8000 7FFF/0015/1",
                     g, outMem[g][20], outMem[g][21], oAddress[g], done[g]);
         end
      end
      // 16 zero residuals: every k finishes exactly on bit 0
      for (int i = 0; i < 18; i++) inMem[40 + i] = '0;
      runEncode(18, 40, 30);
      for (int g = 0; g < NK; g++) begin
         for (int w = 0; w <= g; w++) begin
            tests++;
            if (outMem[g][32 + w] !== fillWords[g][w]) begin
               fails++;
               $display("FAIL fill k=%0d addr=%0d: got %h want %h", g, 32 + w, outMem[g][32 + w], fillWords[g][w]);
            end
         end
         tests++;
         if (oAddress[g] !== ADDR_W'(32 + g) || outMem[g][33 + g] !== 16'hDEAD) begin
            fails++;
            $display("FAIL fill end k=%0d: oA=%h next=%h, want %h / dead", g, oAddress[g], outMem[g][33 + g], ADDR_W'(32 + g));
         end
      end
   endtask

   task automatic test_random();
      int n, iStart, oStart, v;
      for (int it = 0; it < 6; it++) begin
         n      = int'($urandom_range(3, 40));
         iStart = int'($urandom_range(0, 200));
         oStart = int'($urandom_range(0, 600));
         for (int i = 0; i < n; i++) begin
            v = int'($urandom_range(0, 15)) - 8;
            inMem[iStart + i] = 16'(v);
         end
         runEncode(n, iStart, oStart);
         for (int g = 0; g < NK; g++) begin
            modelEncode(g, n, iStart);
            for (int w = 0; w < expQ.size(); w++) begin
               tests++;
               if (outMem[g][oStart + w] !== expQ[w]) begin
                  fails++;
                  $display("FAIL random%0d word k=%0d addr=%0d: got %h want %h", it, g, oStart + w, outMem[g][oStart + w], expQ[w]);
               end
            end
            tests++;
            if (oAddress[g] !== ADDR_W'(oStart + expQ.size() - 1) || done[g] !== 1'b1 || addrViol[g] != 0) begin
               fails++;
               $display("FAIL random%0d end k=%0d: oA=%h done=%b viol=%0d, want %h/1/0",
                        it, g, oAddress[g], done[g], addrViol[g], ADDR_W'(oStart + expQ.size() - 1));
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 6; i++) inMem[i] = '0;
      inMem[2] = 16'sd100;
      startEncode(6, 0, 3);
      repeat (20) @(negedge clk);
      tests++;
      if (done[0] !== 1'b0 || oAddress[0] !== 16'd5) begin
         fails++;
         $display("FAIL midrun k=0: done=%b oA=%h, want 0 / 0005", done[0], oAddress[0]);
      end
      #2 rstN = 1'b0;
      #1;
      for (int g = 0; g < NK; g++) begin
         tests++;
         if (iAddress[g] !== '0 || oAddress[g] !== '0 || oMemory[g] !== '0 || done[g] !== 1'b0) begin
            fails++;
            $display("FAIL abort k=%0d: iA=%h oA=%h oM=%h done=%b, required all 0",
                     g, iAddress[g], oAddress[g], oMemory[g], done[g]);
         end
      end
      runEncode(6, 0, 3);
      for (int g = 0; g < NK; g++) begin
         modelEncode(g, 6, 0);
         for (int w = 0; w < expQ.size(); w++) begin
            tests++;
            if (outMem[g][3 + w] !== expQ[w]) begin
               fails++;
               $display("FAIL rerun word k=%0d addr=%0d: got %h want %h", g, 3 + w, outMem[g][3 + w], expQ[w]);
            end
         end
         tests++;
         if (oAddress[g] !== ADDR_W'(3 + expQ.size() - 1) || done[g] !== 1'b1) begin
            fails++;
            $display("FAIL rerun end k=%0d: oA=%h done=%b, want %h / 1", g, oAddress[g], done[g], ADDR_W'(3 + expQ.size() - 1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_boundary();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
